axi_interconnect_crossbar_resp_demux: RTL and testbench

Parametrised response demultiplexer for the crossbar's response return path (B or R channel). Accepts a single tagged response stream from one slave port, buffers it in a configurable-depth synchronous FIFO, and steers each beat to one of NUM_DEST master ports by its routing tag. The output stage is bubble-free, sustaining one response per cycle. Beats with an out-of-range tag are discarded and flagged rather than stalling the path.

---
 rtl/axi_interconnect_crossbar_resp_demux_pkg.sv | 10 +
 rtl/axi_interconnect_crossbar_resp_demux_if.sv | 27 ++
 rtl/axi_interconnect_crossbar_resp_demux_sync_fifo.sv | 40 ++++
 rtl/axi_interconnect_crossbar_resp_demux.sv | 73 +++++++
 tb/tb_axi_interconnect_crossbar_resp_demux.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/axi_interconnect_crossbar_resp_demux_pkg.sv
// axi_interconnect_crossbar_resp_demux_pkg: shared constants and helper for the response demux
package axi_interconnect_crossbar_resp_demux_pkg;
  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;
  function automatic int log2(input int value);
    int r = 1;
    for (int v = value >> 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/axi_interconnect_crossbar_resp_demux_if.sv
// axi_interconnect_crossbar_resp_demux_if: tagged response stream in, per-destination response ports out
interface axi_interconnect_crossbar_resp_demux_if
  import axi_interconnect_crossbar_resp_demux_pkg::*;
#(
  parameter int NUM_DEST = 4,
  parameter int WIDTH_RESPINFO = 48,
  parameter int WIDTH_DEST = log2(NUM_DEST - 1),
  parameter int WIDTH_LVL = 3
);
  logic [WIDTH_RESPINFO+WIDTH_DEST-1:0] s_resp_info;
  logic s_resp_valid;
  logic s_resp_ready;
  logic [NUM_DEST*WIDTH_RESPINFO-1:0] m_resp_info;
  logic [NUM_DEST-1:0] m_resp_valid;
  logic [NUM_DEST-1:0] m_resp_ready;
  logic [WIDTH_LVL-1:0] fifo_level;
  logic drop_err;
  logic [DROP_CNT_W-1:0] drop_cnt;
  modport slave (
    input s_resp_info, s_resp_valid, m_resp_ready,
    output s_resp_ready, m_resp_info, m_resp_valid, fifo_level, drop_err, drop_cnt
  );
  modport master (
    output s_resp_info, s_resp_valid, m_resp_ready,
    input s_resp_ready, m_resp_info, m_resp_valid, fifo_level, drop_err, drop_cnt
  );
endinterface

// File: rtl/axi_interconnect_crossbar_resp_demux_sync_fifo.sv
// axi_interconnect_crossbar_resp_demux_sync_fifo: single-clock show-ahead FIFO with full/empty/level
module axi_interconnect_crossbar_resp_demux_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int WIDTH_LVL = $clog2(DEPTH) + 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic full_o,
  output logic empty_o,
  output logic [WIDTH_LVL-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en_i);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(rd_en_i);
  assign empty_o = wr_ptr_q == rd_ptr_q;
  assign full_o = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = WIDTH_LVL'(wr_ptr_q - rd_ptr_q);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  // pointer registers; the extra MSB tells full from empty after wrap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // storage array, no reset needed since contents are only read when occupied
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end
endmodule

// File: rtl/axi_interconnect_crossbar_resp_demux.sv
// axi_interconnect_crossbar_resp_demux: tag-routed response demux; AXI_IC_RESP_DEMUX_DROP_CNT_EN enables drop_cnt
module axi_interconnect_crossbar_resp_demux
  import axi_interconnect_crossbar_resp_demux_pkg::*;
#(
  parameter int NUM_DEST = 4,
  parameter int WIDTH_RESPINFO = 48,
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH_DEST = log2(NUM_DEST - 1),
  parameter int WIDTH_LVL = $clog2(FIFO_DEPTH) + 1
) (
  input logic clk_sys,
  input logic rst_n,
  axi_interconnect_crossbar_resp_demux_if.slave bus
);
  localparam int W = WIDTH_RESPINFO + WIDTH_DEST;
  logic [W-1:0] head;
  logic full, empty, out_fire, free, pop, head_ok, load, drop;
  logic out_valid_q, out_valid_d;
  logic [WIDTH_DEST-1:0] out_dest_q, out_dest_d;
  logic [WIDTH_RESPINFO-1:0] out_data_q, out_data_d;
  logic drop_err_q;
  axi_interconnect_crossbar_resp_demux_sync_fifo #(
    .WIDTH(W), .DEPTH(FIFO_DEPTH), .WIDTH_LVL(WIDTH_LVL)
  ) u_fifo (
    .clk_i(clk_sys), .rst_ni(rst_n),
    .wr_en_i(bus.s_resp_valid && !full), .wr_data_i(bus.s_resp_info),
    .rd_en_i(pop), .rd_data_o(head),
    .full_o(full), .empty_o(empty), .level_o(bus.fifo_level)
  );
  assign bus.s_resp_ready = !full;
  assign out_fire = out_valid_q && bus.m_resp_ready[out_dest_q];
  assign free = !out_valid_q || out_fire;
  assign head_ok = 32'(head[WIDTH_DEST-1:0]) < NUM_DEST;
  assign pop = !empty && free;
  assign load = pop && head_ok;
  assign drop = pop && !head_ok;
  // output stage next state: refill from a good head, otherwise hold or drain
  always_comb begin
    out_valid_d = free ? load : out_valid_q;
    out_dest_d = load ? head[WIDTH_DEST-1:0] : out_dest_q;
    out_data_d = load ? head[W-1:WIDTH_DEST] : out_data_q;
  end
  // output register and registered discard pulse
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_dest_q <= '0;
      out_data_q <= '0;
      drop_err_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_dest_q <= out_dest_d;
      out_data_q <= out_data_d;
      drop_err_q <= drop;
    end
  end
  for (genvar i = 0; i < NUM_DEST; i++) begin : g_valid
    assign bus.m_resp_valid[i] = out_valid_q && (32'(out_dest_q) == i);
  end
  assign bus.m_resp_info = {NUM_DEST{out_data_q}};
  assign bus.drop_err = drop_err_q;
`ifdef AXI_IC_RESP_DEMUX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  // saturating count of discarded beats
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else drop_cnt_q <= (drop && drop_cnt_q != DROP_CNT_MAX) ? drop_cnt_q + 1'b1 : drop_cnt_q;
  end
  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = '0;
`endif
endmodule

// File: tb/tb_axi_interconnect_crossbar_resp_demux.sv
// tb_axi_interconnect_crossbar_resp_demux: directed checks of routing, backpressure, discard, ordering and reset
module tb_axi_interconnect_crossbar_resp_demux;
`ifdef AXI_IC_RESP_DEMUX_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic clk_sys = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk_sys = ~clk_sys;
  axi_interconnect_crossbar_resp_demux_if #(.NUM_DEST(4), .WIDTH_RESPINFO(16), .WIDTH_DEST(2), .WIDTH_LVL(3)) a ();
  axi_interconnect_crossbar_resp_demux_if #(.NUM_DEST(3), .WIDTH_RESPINFO(16), .WIDTH_DEST(2), .WIDTH_LVL(3)) b ();
  axi_interconnect_crossbar_resp_demux #(.NUM_DEST(4), .WIDTH_RESPINFO(16), .FIFO_DEPTH(4), .WIDTH_DEST(2), .WIDTH_LVL(3))
    dut4 (.clk_sys(clk_sys), .rst_n(rst_n), .bus(a));
  axi_interconnect_crossbar_resp_demux #(.NUM_DEST(3), .WIDTH_RESPINFO(16), .FIFO_DEPTH(4), .WIDTH_DEST(2), .WIDTH_LVL(3))
    dut3 (.clk_sys(clk_sys), .rst_n(rst_n), .bus(b));

  task automatic test_reset;
    n_cmp++; if (a.m_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_valid got %b exp %b", a.m_resp_valid, 4'b0000); end
    n_cmp++; if (a.m_resp_info !== 64'h0) begin n_bad++; $display("FAIL reset_info got %h exp 0", a.m_resp_info); end
    n_cmp++; if (a.fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d exp 0", a.fifo_level); end
    n_cmp++; if (a.s_resp_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", a.s_resp_ready); end
    n_cmp++; if (a.drop_err !== 1'b0) begin n_bad++; $display("FAIL reset_drop_err got %b exp 0", a.drop_err); end
    n_cmp++; if (b.drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop_cnt got %0d exp 0", b.drop_cnt); end
  endtask

  task automatic test_route;
    a.m_resp_ready = 4'hF;
    a.s_resp_valid = 1'b1; a.s_resp_info = {16'hA002, 2'd2};
    @(negedge clk_sys); a.s_resp_info = {16'hA000, 2'd0};
    n_cmp++; if (a.m_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL route_latency got %b exp %b", a.m_resp_valid, 4'b0000); end
    @(negedge clk_sys); a.s_resp_info = {16'hA003, 2'd3};
    n_cmp++; if (a.m_resp_valid !== 4'b0100) begin n_bad++; $display("FAIL route_v2 got %b exp %b", a.m_resp_valid, 4'b0100); end
    n_cmp++; if (a.m_resp_info !== {4{16'hA002}}) begin n_bad++; $display("FAIL route_d2 got %h exp %h", a.m_resp_info, {4{16'hA002}}); end
    @(negedge clk_sys); a.s_resp_valid = 1'b0;
    n_cmp++; if (a.m_resp_valid !== 4'b0001) begin n_bad++; $display("FAIL route_v0 got %b exp %b", a.m_resp_valid, 4'b0001); end
    n_cmp++; if (a.m_resp_info !== {4{16'hA000}}) begin n_bad++; $display("FAIL route_d0 got %h exp %h", a.m_resp_info, {4{16'hA000}}); end
    @(negedge clk_sys);
    n_cmp++; if (a.m_resp_valid !== 4'b1000) begin n_bad++; $display("FAIL route_v3 got %b exp %b", a.m_resp_valid, 4'b1000); end
    n_cmp++; if (a.m_resp_info !== {4{16'hA003}}) begin n_bad++; $display("FAIL route_d3 got %h exp %h", a.m_resp_info, {4{16'hA003}}); end
    @(negedge clk_sys);
    n_cmp++; if (a.m_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL route_idle got %b exp %b", a.m_resp_valid, 4'b0000); end
  endtask

  task automatic test_backpressure;
    int acc = 0;
    int cyc = 0;
    logic ok;
    logic [15:0] p;
    a.m_resp_ready = 4'b1101;
    a.s_resp_valid = 1'b1;
    while (acc < 5 && cyc < 20) begin
      a.s_resp_info = {16'(16'hB000 + acc), 2'd1};
      ok = a.s_resp_ready;
      @(negedge clk_sys);
      if (ok) acc++;
      cyc++;
    end
    a.s_resp_info = {16'hB005, 2'd1};
    n_cmp++; if (cyc !== 5) begin n_bad++; $display("FAIL bp_accept_cycles got %0d exp 5", cyc); end
    n_cmp++; if (a.s_resp_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_low got %b exp 0", a.s_resp_ready); end
    n_cmp++; if (a.fifo_level !== 3'd4) begin n_bad++; $display("FAIL bp_level got %0d exp 4", a.fifo_level); end
    repeat (2) @(negedge clk_sys);
    n_cmp++; if (a.fifo_level !== 3'd4) begin n_bad++; $display("FAIL bp_level_hold got %0d exp 4", a.fifo_level); end
    for (int k = 0; k < 6; k++) begin
      p = 16'hB000 + 16'(k);
      if (k == 0) begin
        n_cmp++; if (a.s_resp_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_stall got %b exp 0", a.s_resp_ready); end
        a.m_resp_ready = 4'hF;
      end
      if (k == 1) begin
        n_cmp++; if (a.s_resp_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop got %b exp 1", a.s_resp_ready); end
      end
      if (k == 2) a.s_resp_valid = 1'b0;
      n_cmp++; if (a.m_resp_valid !== 4'b0010) begin n_bad++; $display("FAIL bp_valid_%0d got %b exp %b", k, a.m_resp_valid, 4'b0010); end
      n_cmp++; if (a.m_resp_info !== {4{p}}) begin n_bad++; $display("FAIL bp_data_%0d got %h exp %h", k, a.m_resp_info, {4{p}}); end
      @(negedge clk_sys);
    end
    n_cmp++; if (a.m_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL bp_drain got %b exp %b", a.m_resp_valid, 4'b0000); end
    n_cmp++; if (a.fifo_level !== 3'd0) begin n_bad++; $display("FAIL bp_level_end got %0d exp 0", a.fifo_level); end
  endtask

  task automatic test_hol;
    a.m_resp_ready = 4'b1011;
    a.s_resp_valid = 1'b1; a.s_resp_info = {16'hD002, 2'd2};
    @(negedge clk_sys); a.s_resp_info = {16'hD000, 2'd0};
    @(negedge clk_sys); a.s_resp_info = {16'hD010, 2'd0};
    @(negedge clk_sys); a.s_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (a.m_resp_valid !== 4'b0100) begin n_bad++; $display("FAIL hol_stall_v%0d got %b exp %b", k, a.m_resp_valid, 4'b0100); end
      n_cmp++; if (a.fifo_level !== 3'd2) begin n_bad++; $display("FAIL hol_level%0d got %0d exp 2", k, a.fifo_level); end
      @(negedge clk_sys);
    end
    n_cmp++; if (a.m_resp_info !== {4{16'hD002}}) begin n_bad++; $display("FAIL hol_head got %h exp %h", a.m_resp_info, {4{16'hD002}}); end
    a.m_resp_ready = 4'hF;
    @(negedge clk_sys);
    n_cmp++; if (a.m_resp_valid !== 4'b0001) begin n_bad++; $display("FAIL hol_v0a got %b exp %b", a.m_resp_valid, 4'b0001); end
    n_cmp++; if (a.m_resp_info !== {4{16'hD000}}) begin n_bad++; $display("FAIL hol_d0a got %h exp %h", a.m_resp_info, {4{16'hD000}}); end
    @(negedge clk_sys);
    n_cmp++; if (a.m_resp_info !== {4{16'hD010}}) begin n_bad++; $display("FAIL hol_d0b got %h exp %h", a.m_resp_info, {4{16'hD010}}); end
    @(negedge clk_sys);
    n_cmp++; if (a.m_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL hol_idle got %b exp %b", a.m_resp_valid, 4'b0000); end
  endtask

  task automatic test_drop;
    b.m_resp_ready = 3'b111;
    b.s_resp_valid = 1'b1; b.s_resp_info = {16'hC000, 2'd0};
    @(negedge clk_sys); b.s_resp_info = {16'hC003, 2'd3};
    n_cmp++; if (b.drop_err !== 1'b0) begin n_bad++; $display("FAIL drop_err_pre got %b exp 0", b.drop_err); end
    @(negedge clk_sys); b.s_resp_info = {16'hC001, 2'd1};
    n_cmp++; if (b.m_resp_valid !== 3'b001) begin n_bad++; $display("FAIL drop_v0 got %b exp %b", b.m_resp_valid, 3'b001); end
    n_cmp++; if (b.m_resp_info !== {3{16'hC000}}) begin n_bad++; $display("FAIL drop_d0 got %h exp %h", b.m_resp_info, {3{16'hC000}}); end
    @(negedge clk_sys); b.s_resp_valid = 1'b0;
    n_cmp++; if (b.m_resp_valid !== 3'b000) begin n_bad++; $display("FAIL drop_gap got %b exp %b", b.m_resp_valid, 3'b000); end
    n_cmp++; if (b.drop_err !== 1'b1) begin n_bad++; $display("FAIL drop_err_pulse got %b exp 1", b.drop_err); end
    n_cmp++; if (b.drop_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL drop_cnt1 got %0d exp %0d", b.drop_cnt, CNT_EN ? 1 : 0); end
    @(negedge clk_sys);
    n_cmp++; if (b.m_resp_valid !== 3'b010) begin n_bad++; $display("FAIL drop_v1 got %b exp %b", b.m_resp_valid, 3'b010); end
    n_cmp++; if (b.m_resp_info !== {3{16'hC001}}) begin n_bad++; $display("FAIL drop_d1 got %h exp %h", b.m_resp_info, {3{16'hC001}}); end
    n_cmp++; if (b.drop_err !== 1'b0) begin n_bad++; $display("FAIL drop_err_once got %b exp 0", b.drop_err); end
    @(negedge clk_sys);
    n_cmp++; if (b.m_resp_valid !== 3'b000) begin n_bad++; $display("FAIL drop_idle got %b exp %b", b.m_resp_valid, 3'b000); end
  endtask

  task automatic test_drop_twice;
    b.s_resp_valid = 1'b1; b.s_resp_info = {16'hF003, 2'd3};
    @(negedge clk_sys); b.s_resp_info = {16'hF013, 2'd3};
    @(negedge clk_sys); b.s_resp_valid = 1'b0;
    n_cmp++; if (b.drop_err !== 1'b1) begin n_bad++; $display("FAIL drop2_first got %b exp 1", b.drop_err); end
    n_cmp++; if (b.m_resp_valid !== 3'b000) begin n_bad++; $display("FAIL drop2_valid got %b exp %b", b.m_resp_valid, 3'b000); end
    @(negedge clk_sys);
    n_cmp++; if (b.drop_err !== 1'b1) begin n_bad++; $display("FAIL drop2_second got %b exp 1", b.drop_err); end
    @(negedge clk_sys);
    n_cmp++; if (b.drop_err !== 1'b0) begin n_bad++; $display("FAIL drop2_end got %b exp 0", b.drop_err); end
    n_cmp++; if (b.drop_cnt !== (CNT_EN ? 16'd3 : 16'd0)) begin n_bad++; $display("FAIL drop2_cnt got %0d exp %0d", b.drop_cnt, CNT_EN ? 3 : 0); end
    n_cmp++; if (b.fifo_level !== 3'd0) begin n_bad++; $display("FAIL drop2_level got %0d exp 0", b.fifo_level); end
  endtask

  task automatic test_async_reset;
    a.m_resp_ready = 4'b1101;
    a.s_resp_valid = 1'b1; a.s_resp_info = {16'hE001, 2'd1};
    @(negedge clk_sys); a.s_resp_info = {16'hE011, 2'd1};
    @(negedge clk_sys); a.s_resp_info = {16'hE021, 2'd1};
    @(negedge clk_sys); a.s_resp_valid = 1'b0;
    n_cmp++; if (a.fifo_level !== 3'd2) begin n_bad++; $display("FAIL ar_level_pre got %0d exp 2", a.fifo_level); end
    n_cmp++; if (a.m_resp_valid !== 4'b0010) begin n_bad++; $display("FAIL ar_valid_pre got %b exp %b", a.m_resp_valid, 4'b0010); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (a.m_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL ar_valid got %b exp %b", a.m_resp_valid, 4'b0000); end
    n_cmp++; if (a.m_resp_info !== 64'h0) begin n_bad++; $display("FAIL ar_info got %h exp 0", a.m_resp_info); end
    n_cmp++; if (a.fifo_level !== 3'd0) begin n_bad++; $display("FAIL ar_level got %0d exp 0", a.fifo_level); end
    n_cmp++; if (b.drop_cnt !== 16'd0) begin n_bad++; $display("FAIL ar_drop_cnt got %0d exp 0", b.drop_cnt); end
    @(negedge clk_sys);
    rst_n = 1'b1;
    a.m_resp_ready = 4'hF;
    a.s_resp_valid = 1'b1; a.s_resp_info = {16'hE103, 2'd3};
    @(negedge clk_sys); a.s_resp_valid = 1'b0;
    n_cmp++; if (a.m_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL ar_latency got %b exp %b", a.m_resp_valid, 4'b0000); end
    @(negedge clk_sys);
    n_cmp++; if (a.m_resp_valid !== 4'b1000) begin n_bad++; $display("FAIL ar_new_valid got %b exp %b", a.m_resp_valid, 4'b1000); end
    n_cmp++; if (a.m_resp_info !== {4{16'hE103}}) begin n_bad++; $display("FAIL ar_new_data got %h exp %h", a.m_resp_info, {4{16'hE103}}); end
    @(negedge clk_sys);
    n_cmp++; if (a.m_resp_valid !== 4'b0000) begin n_bad++; $display("FAIL ar_idle got %b exp %b", a.m_resp_valid, 4'b0000); end
  endtask

  initial begin
    a.s_resp_valid = 1'b0; a.s_resp_info = '0; a.m_resp_ready = 4'hF;
    b.s_resp_valid = 1'b0; b.s_resp_info = '0; b.m_resp_ready = 3'b111;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    test_reset();
    test_route();
    test_backpressure();
    test_hol();
    test_drop();
    test_drop_twice();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
